// File: rtl/pll_seq_pkg.sv
// Shared state encoding and sizing helpers for the PLL reset/lock sequencer.
package pll_seq_pkg;

    localparam int STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        PLL_RST   = 3'd0,
        WAIT_LOCK = 3'd1,
        STABLE    = 3'd2,
        RUN       = 3'd3,
        FAIL      = 3'd4
    } state_e;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop single-bit synchronizer; output resets low.
module sync_2ff (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/pll_rst_seq.sv
// PLL reset/lock sequencer: pulses the PLL reset, waits for a stable lock, then releases sys_rst_n.
//   state     | meaning
//   PLL_RST   | PLL held in reset for RST_PULSE_CYCLES
//   WAIT_LOCK | waiting for locked_s, bounded by LOCK_TIMEOUT_CYCLES
//   STABLE    | locked_s must stay high for LOCK_STABLE_CYCLES
//   RUN       | system reset released; lock loss restarts the sequence
//   FAIL      | retries exhausted; PLL held in reset until soft_reset/rst_n
module pll_rst_seq
    import pll_seq_pkg::*;
#(
    parameter int RST_PULSE_CYCLES    = 50,
    parameter int LOCK_TIMEOUT_CYCLES = 50000,
    parameter int LOCK_STABLE_CYCLES  = 1024,
    parameter int MAX_RETRIES         = 3,
    localparam int RETRY_W = (MAX_RETRIES < 1) ? 1 : $clog2(MAX_RETRIES + 1)
) (
    input  logic               refclk,
    input  logic               rst_n,
    input  logic               soft_reset,
    input  logic               locked,
    output logic               pll_rst,
    output logic               sys_rst_n,
    output logic               pll_ready,
    output logic               fail,
    output logic               lock_lost,
    output logic [RETRY_W-1:0] retry_cnt,
    output logic [STATE_W-1:0] state
);

    localparam int CNT_MAX = max3(RST_PULSE_CYCLES, LOCK_TIMEOUT_CYCLES, LOCK_STABLE_CYCLES);
    localparam int CNT_W   = (CNT_MAX < 2) ? 1 : $clog2(CNT_MAX);

    localparam logic [CNT_W-1:0]   RST_TC = CNT_W'(RST_PULSE_CYCLES - 1);
    localparam logic [CNT_W-1:0]   TMO_TC = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0]   STB_TC = CNT_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [RETRY_W-1:0] RETRY_LIMIT = RETRY_W'(MAX_RETRIES);

    logic               locked_s;
    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [RETRY_W-1:0] retry_q, retry_d;
    logic               lost_q, lost_d;
    logic               pll_rst_q, sys_rst_n_q, ready_q, fail_q;

    sync_2ff u_lock_sync (
        .clk   (refclk),
        .rst_n (rst_n),
        .d     (locked),
        .q     (locked_s)
    );

    always_comb begin
        state_d = state_q;
        retry_d = retry_q;
        lost_d  = lost_q;
        if (soft_reset) begin
            state_d = PLL_RST;
            retry_d = '0;
            lost_d  = 1'b0;
        end else begin
            case (state_q)
                PLL_RST: if (cnt_q == RST_TC) state_d = WAIT_LOCK;
                WAIT_LOCK: begin
                    // lock takes precedence over a timeout in the same cycle
                    if (locked_s) begin
                        state_d = STABLE;
                    end else if (cnt_q == TMO_TC) begin
                        if (retry_q < RETRY_LIMIT) begin
                            retry_d = retry_q + 1'b1;
                            state_d = PLL_RST;
                        end else begin
                            state_d = FAIL;
                        end
                    end
                end
                STABLE: begin
                    if (!locked_s) begin
                        state_d = WAIT_LOCK;
                    end else if (cnt_q == STB_TC) begin
                        state_d = RUN;
                        retry_d = '0;
                    end
                end
                RUN: begin
                    if (!locked_s) begin
                        lost_d  = 1'b1;
                        state_d = PLL_RST;
                    end
                end
                FAIL:    state_d = FAIL;
                default: state_d = PLL_RST;
            endcase
        end

        if (soft_reset || (state_d != state_q)) begin
            cnt_d = '0;
        end else if (state_q inside {RUN, FAIL}) begin
            cnt_d = cnt_q;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= PLL_RST;
            cnt_q       <= '0;
            retry_q     <= '0;
            lost_q      <= 1'b0;
            pll_rst_q   <= 1'b1;
            sys_rst_n_q <= 1'b0;
            ready_q     <= 1'b0;
            fail_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            retry_q     <= retry_d;
            lost_q      <= lost_d;
            pll_rst_q   <= (state_d == PLL_RST) || (state_d == FAIL);
            sys_rst_n_q <= (state_d == RUN);
            ready_q     <= (state_d == RUN);
            fail_q      <= (state_d == FAIL);
        end
    end

    assign pll_rst   = pll_rst_q;
    assign sys_rst_n = sys_rst_n_q;
    assign pll_ready = ready_q;
    assign fail      = fail_q;
    assign lock_lost = lost_q;
    assign retry_cnt = retry_q;
    assign state     = state_q;

endmodule

// File: tb/tb_pll_rst_seq.sv
// Bench for pll_rst_seq: directed scenarios plus random lock traffic against a cycle-level reference model.
module tb_pll_rst_seq;

    localparam int RP = 4;
    localparam int TO = 20;
    localparam int ST = 8;
    localparam int MR = 2;

    logic       refclk = 1'b0;
    logic       rst_n = 1'b0;
    logic       soft_reset = 1'b0;
    logic       locked = 1'b0;
    logic       pll_rst, sys_rst_n, pll_ready, fail, lock_lost;
    logic [1:0] retry_cnt;
    logic [2:0] state;

    int    n_total = 0;
    int    n_bad = 0;
    string phase = "init";

    // reference model: mode uses the documented debug encodings 0..4
    int m_mode, m_age, m_retry;
    bit m_lost;
    bit hist[$];

    int k, first_stable, first_rel, first_fail, n_rst_hi, max_retry;

    always #5 refclk = ~refclk;

    pll_rst_seq #(
        .RST_PULSE_CYCLES    (RP),
        .LOCK_TIMEOUT_CYCLES (TO),
        .LOCK_STABLE_CYCLES  (ST),
        .MAX_RETRIES         (MR)
    ) dut (
        .refclk     (refclk),
        .rst_n      (rst_n),
        .soft_reset (soft_reset),
        .locked     (locked),
        .pll_rst    (pll_rst),
        .sys_rst_n  (sys_rst_n),
        .pll_ready  (pll_ready),
        .fail       (fail),
        .lock_lost  (lock_lost),
        .retry_cnt  (retry_cnt),
        .state      (state)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input int exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0d want=%0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic void go(input int md);
        m_mode = md;
        m_age  = 0;
    endfunction

    function automatic void model_reset();
        go(0);
        m_retry = 0;
        m_lost  = 1'b0;
        hist.delete();
        hist.push_back(1'b0);
        hist.push_back(1'b0);
    endfunction

    // locked as seen through the synchronizer lags the driven value by three edges
    function automatic void model_step();
        bit ls;
        ls = hist.pop_front();
        hist.push_back(locked);
        m_age++;
        if (soft_reset) begin
            go(0);
            m_retry = 0;
            m_lost  = 1'b0;
        end else begin
            case (m_mode)
                0: if (m_age == RP) go(1);
                1: begin
                    if (ls) go(2);
                    else if (m_age == TO) begin
                        if (m_retry < MR) begin
                            m_retry++;
                            go(0);
                        end else go(4);
                    end
                end
                2: begin
                    if (!ls) go(1);
                    else if (m_age == ST) begin
                        m_retry = 0;
                        go(3);
                    end
                end
                3: if (!ls) begin
                    m_lost = 1'b1;
                    go(0);
                end
                default: ;
            endcase
        end
    endfunction

    task automatic compare_all(input string pfx);
        check_eq({pfx, ".state"},     state,     m_mode);
        check_eq({pfx, ".pll_rst"},   pll_rst,   int'(m_mode == 0 || m_mode == 4));
        check_eq({pfx, ".sys_rst_n"}, sys_rst_n, int'(m_mode == 3));
        check_eq({pfx, ".pll_ready"}, pll_ready, int'(m_mode == 3));
        check_eq({pfx, ".fail"},      fail,      int'(m_mode == 4));
        check_eq({pfx, ".lock_lost"}, lock_lost, int'(m_lost));
        check_eq({pfx, ".retry_cnt"}, retry_cnt, m_retry);
    endtask

    function automatic void track();
        if (state == 3'd2 && first_stable < 0) first_stable = k;
        if (sys_rst_n && first_rel < 0) first_rel = k;
        if (state == 3'd4 && first_fail < 0) first_fail = k;
        if (pll_rst) n_rst_hi++;
        if (int'(retry_cnt) > max_retry) max_retry = int'(retry_cnt);
    endfunction

    // drives sr/lk for the interval that starts just after this edge
    task automatic tick(input bit sr, input bit lk);
        @(posedge refclk);
        if (rst_n) model_step();
        #1;
        soft_reset = sr;
        locked     = lk;
        @(negedge refclk);
        k++;
        compare_all(phase);
        track();
    endtask

    task automatic apply_reset(input int hold, input bit chk_async);
        rst_n      = 1'b0;
        soft_reset = 1'b0;
        locked     = 1'b0;
        #1;
        model_reset();
        if (chk_async) compare_all({phase, ".async"});
        repeat (hold + 1) @(posedge refclk);
        #1;
        rst_n = 1'b1;
        @(negedge refclk);
        k = 0;
        first_stable = -1;
        first_rel    = -1;
        first_fail   = -1;
        n_rst_hi     = 0;
        max_retry    = 0;
        compare_all({phase, ".rel"});
        track();
    endtask

    initial begin
        // nominal lock at interval 10
        phase = "nominal";
        apply_reset(2, 1'b0);
        for (int i = 1; i <= 40; i++) tick(1'b0, i >= 10);
        check_eq("nom.rst_pulse", n_rst_hi, RP);
        check_eq("nom.stable_at", first_stable, 13);
        check_eq("nom.release_gap", first_rel - first_stable, ST);
        check_eq("nom.retry", retry_cnt, 0);

        // two timeouts then lock; lock_at=45 lands exactly on the second timeout edge
        for (int r = 0; r < 2; r++) begin
            int lock_at;
            phase   = (r == 0) ? "retry_edge" : "retry";
            lock_at = (r == 0) ? 45 : int'($urandom_range(46, 66));
            apply_reset(1, 1'b1);
            for (int i = 1; i <= 110; i++) tick(1'b0, i >= lock_at);
            check_eq({phase, ".max_retry"}, max_retry, (r == 0) ? 1 : 2);
            check_eq({phase, ".rst_hi"}, n_rst_hi, (r == 0) ? 2 * RP : 3 * RP);
            check_eq({phase, ".final_state"}, state, 3);
            check_eq({phase, ".final_retry"}, retry_cnt, 0);
        end

        // permanent failure, then soft_reset recovery
        phase = "fail";
        apply_reset(1, 1'b1);
        for (int i = 1; i <= 80; i++) tick(1'b0, 1'b0);
        check_eq("fail.at", first_fail, 3 * (RP + TO));
        check_eq("fail.flag", fail, 1);
        check_eq("fail.pll_rst", pll_rst, 1);
        tick(1'b1, 1'b0);
        tick(1'b0, 1'b1);
        check_eq("fail.sr_state", state, 0);
        check_eq("fail.sr_fail", fail, 0);
        check_eq("fail.sr_retry", retry_cnt, 0);
        for (int i = 0; i < 30; i++) tick(1'b0, 1'b1);
        check_eq("fail.recover", state, 3);

        // 3-cycle glitch while in STABLE
        phase = "glitch";
        apply_reset(1, 1'b1);
        for (int i = 1; i <= 40; i++) begin
            tick(1'b0, (i >= 2) && !(i >= 8 && i <= 10));
            if (i == 11) check_eq("glitch.back_wait", state, 1);
        end
        check_eq("glitch.stable_at", first_stable, 5);
        check_eq("glitch.release_at", first_rel, 22);

        // lock loss in RUN, then relock keeps the sticky flag
        phase = "loss";
        for (int i = 0; i < 3; i++) tick(1'b0, 1'b0);
        check_eq("loss.still_up", sys_rst_n, 1);
        tick(1'b0, 1'b1);
        check_eq("loss.sys_rst_n", sys_rst_n, 0);
        check_eq("loss.pll_rst", pll_rst, 1);
        check_eq("loss.flag", lock_lost, 1);
        for (int i = 0; i < 30; i++) tick(1'b0, 1'b1);
        check_eq("loss.relock_state", state, 3);
        check_eq("loss.sticky", lock_lost, 1);

        // soft_reset in the same cycle locked_s falls in RUN
        phase = "sr_loss";
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b0);
        tick(1'b1, 1'b0);
        tick(1'b0, 1'b1);
        check_eq("sr_loss.flag", lock_lost, 0);
        check_eq("sr_loss.state", state, 0);
        for (int i = 0; i < 30; i++) tick(1'b0, 1'b1);

        // asynchronous reset while waiting for lock
        phase = "wl_rst";
        apply_reset(1, 1'b1);
        for (int i = 1; i <= 6; i++) tick(1'b0, 1'b0);
        check_eq("wl_rst.pre_state", state, 1);
        apply_reset(1, 1'b1);

        // random lock traffic with occasional soft and hard resets
        phase = "rand";
        for (int seg = 0; seg < 80; seg++) begin
            bit lv;
            int len;
            lv  = ($urandom_range(0, 3) != 0);
            len = int'($urandom_range(1, 40));
            for (int j = 0; j < len; j++) tick($urandom_range(0, 99) == 0, lv);
            if ($urandom_range(0, 19) == 0) apply_reset(int'($urandom_range(0, 3)), 1'b1);
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
